// File: rtl/serial_adder_ctrl_pkg.sv
`timescale 1ns/1ns
// serial_add_pkg
// Shared definitions for the bit-serial adder controller: the controller
// state encoding, the smallest legal settle time and the helper that sizes
// the bit-index register.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int MIN_SETTLE = 1;

  // Bits needed to count 0..width-1. Kept at least 1 so the index register
  // never collapses to zero width.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_settle.sv
`timescale 1ns/1ns
// settle_timer
// Counts the cycles during which the full-adder cell inputs are held stable.
// expired is high while the count sits on its last value, so the controller
// can leave its wait state on that same edge.
//
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   clear   : return the count to 0 (operand load or bit capture)
//   enable  : advance the count by one
//   expired : count has reached SETTLE-1
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import serial_add_pkg::*;

  // A settle time below the minimum is clamped rather than producing a
  // degenerate counter.
  localparam int TERM = (SETTLE < MIN_SETTLE) ? MIN_SETTLE : SETTLE;
  localparam int CW   = (TERM > 1) ? $clog2(TERM) : 1;

  logic [CW-1:0] cnt;

  // Settle counter: clear has priority so a capture restarts the wait for
  // the next bit even if enable is also asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expiry decode; with TERM of 1 this is permanently true, giving a single
  // wait cycle per bit.
  always_comb begin
    expired = (cnt == CW'(TERM - 1));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ns
// serial_adder_ctrl
// Sequences an external 1-bit full-adder cell through a WIDTH-bit bit-serial
// addition. Operands are latched on an accepted start; each bit pair plus the
// stored carry is presented to the cell, held for SETTLE cycles so the cell's
// propagation delay can elapse, then sampled in a single CAPTURE cycle.
// After the last bit, done pulses for one cycle with sum/cout updated.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, only honoured in IDLE
//   a, b, cin       : operands and carry-in, latched on accepted start
//   busy            : high from the cycle after start through the DONE cycle
//   done            : one-cycle completion pulse
//   sum, cout       : result, held until the next completion
//   fa_a/fa_b/fa_c  : registered drive to the cell inputs
//   fa_s/fa_co      : cell sum and carry outputs, sampled only in CAPTURE
//
// The SETTLE parameter hides the SETTLE state label imported from the
// package, so that state is always written with its package scope here.
module serial_adder_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co
);
  import serial_add_pkg::*;

  localparam int IW = idx_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic             last_bit;
  logic             active;
  logic             tmr_clear;
  logic             tmr_en;
  logic             expired;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Cell inputs are only driven while a bit
  // is in flight; in IDLE and DONE they are gated to 0 so the stale final
  // carry never reaches the cell between operations.
  always_comb begin
    state_nxt = state;
    last_bit  = (idx == IW'(WIDTH - 1));
    active    = (state == serial_add_pkg::SETTLE) || (state == CAPTURE);
    tmr_clear = (state == IDLE) || (state == CAPTURE);
    tmr_en    = (state == serial_add_pkg::SETTLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    fa_a      = active & a_sh[0];
    fa_b      = active & b_sh[0];
    fa_c      = active & carry_r;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = serial_add_pkg::SETTLE;
        end
      end
      serial_add_pkg::SETTLE: begin
        if (expired) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = last_bit ? DONE : serial_add_pkg::SETTLE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. The accumulator fills from the top so that after WIDTH
  // captures bit 0 sits in the LSB. sum/cout are loaded straight from the
  // capture value on the last bit, so they change only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= cin;
            idx     <= '0;
            acc     <= '0;
          end
        end
        CAPTURE: begin
          acc     <= {fa_s, acc[WIDTH-1:1]};
          carry_r <= fa_co;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          if (last_bit) begin
            sum  <= {fa_s, acc[WIDTH-1:1]};
            cout <= fa_co;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ns
// tb_serial_adder_ctrl
// Bench for the bit-serial adder controller with a delayed full-adder cell
// model in the loop. The main instance uses the default settle time; two
// extra instances share a slower cell model to show that a too-short settle
// time samples stale cell outputs while a long enough one does not.
module tb_serial_adder_ctrl;

  localparam int W        = 8;
  localparam int S        = 2;
  localparam int PER      = S + 1;
  localparam int DONE_CYC = W * PER + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] carries;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start_slow = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;

  logic         busy, done, cout, fa_a, fa_b, fa_c;
  logic [W-1:0] sum;
  wire          fa_s, fa_co;

  logic         s1_busy, s1_done, s1_cout, s1_fa_a, s1_fa_b, s1_fa_c;
  logic [W-1:0] s1_sum;
  wire          s1_fa_s, s1_fa_co;
  logic         s3_busy, s3_done, s3_cout, s3_fa_a, s3_fa_b, s3_fa_c;
  logic [W-1:0] s3_sum;
  wire          s3_fa_s, s3_fa_co;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;
  vec_t         vecs[6];
  vec_t         post_vec;

  // 20 ns clock period.
  always #10 clk = ~clk;

  // Full-adder cell models: 30 ns for the main cell, 50 ns for the slow one.
  assign #30 fa_s     = fa_a ^ fa_b ^ fa_c;
  assign #30 fa_co    = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));
  assign #50 s1_fa_s  = s1_fa_a ^ s1_fa_b ^ s1_fa_c;
  assign #50 s1_fa_co = (s1_fa_a & s1_fa_b) | (s1_fa_c & (s1_fa_a ^ s1_fa_b));
  assign #50 s3_fa_s  = s3_fa_a ^ s3_fa_b ^ s3_fa_c;
  assign #50 s3_fa_co = (s3_fa_a & s3_fa_b) | (s3_fa_c & (s3_fa_a ^ s3_fa_b));

  serial_adder_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_co(fa_co)
  );

  serial_adder_ctrl #(.WIDTH(W), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start_slow), .a(a), .b(b), .cin(cin),
    .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout),
    .fa_a(s1_fa_a), .fa_b(s1_fa_b), .fa_c(s1_fa_c), .fa_s(s1_fa_s), .fa_co(s1_fa_co)
  );

  serial_adder_ctrl #(.WIDTH(W), .SETTLE(3)) dut_s3 (
    .clk(clk), .rst(rst), .start(start_slow), .a(a), .b(b), .cin(cin),
    .busy(s3_busy), .done(s3_done), .sum(s3_sum), .cout(s3_cout),
    .fa_a(s3_fa_a), .fa_b(s3_fa_b), .fa_c(s3_fa_c), .fa_s(s3_fa_s), .fa_co(s3_fa_co)
  );

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Presents operands with start for one edge (edge 0), then scrambles the
  // operand inputs so any late sampling would show. Returns in cycle 1.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = ~v.a;
    b     = ~v.b;
    cin   = ~v.cin;
  endtask

  // Runs one addition over a fixed cycle window and checks timing, result,
  // carry sequence seen by the cell, busy window, result hold and gating.
  // A nonzero restart_cyc re-pulses start with different operands then.
  task automatic runAndCheck(input vec_t v, input int restart_cyc, input string tag);
    int           done_cyc;
    int           done_cnt;
    logic         busy_ok;
    logic         hold_ok;
    logic         idle_ok;
    logic [W-1:0] fac;
    logic [W-1:0] got_sum;
    logic         got_cout;
    done_cyc = 0;
    done_cnt = 0;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;
    idle_ok  = 1'b1;
    fac      = '0;
    got_sum  = '0;
    got_cout = 1'b0;
    applyStimulus(v);
    for (int cyc = 1; cyc <= DONE_CYC + 4; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (restart_cyc > 0 && cyc == restart_cyc) begin
        a     = ~v.a;
        b     = ~v.b;
        cin   = ~v.cin;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy !== (cyc <= DONE_CYC)) busy_ok = 1'b0;
      if (cyc < DONE_CYC && (sum !== prev_sum || cout !== prev_cout)) hold_ok = 1'b0;
      if ((cyc - 1) % PER == 0 && (cyc - 1) / PER < W) fac[(cyc - 1) / PER] = fa_c;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          got_sum  = sum;
          got_cout = cout;
          if ((fa_a | fa_b | fa_c) !== 1'b0) idle_ok = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput({tag, "_done_cycle"}, done_cyc, DONE_CYC);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_sum"}, got_sum, v.sum);
    checkOutput({tag, "_cout"}, got_cout, v.cout);
    checkOutput({tag, "_carry_seq"}, fac, v.carries);
    checkOutput({tag, "_busy_window"}, busy_ok, 1);
    checkOutput({tag, "_result_hold"}, hold_ok, 1);
    checkOutput({tag, "_fa_gated_in_done"}, idle_ok, 1);
    prev_sum  = v.sum;
    prev_cout = v.cout;
  endtask

  initial begin
    int           s1_cyc;
    int           s3_cyc;
    logic [W-1:0] s1_res;
    logic [W-1:0] s3_res;
    logic         s3_co;

    //          a      b      cin   sum    cout  carry into each bit
    vecs[0] = '{8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 8'hF8};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFE};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 8'h01};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 8'h00};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00};
    post_vec = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 8'h61};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    checkOutput("reset_fa", {fa_a, fa_b, fa_c}, 0);
    rst = 1'b0;

    // Table-driven additions.
    for (int i = 0; i < 6; i++) begin
      runAndCheck(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Start re-pulsed in cycle 10 with other operands must be ignored.
    runAndCheck(vecs[0], 10, "restart");

    // Asynchronous reset in the middle of cycle 12.
    applyStimulus(vecs[0]);
    for (int cyc = 2; cyc <= 12; cyc++) @(negedge clk);
    checkOutput("pre_reset_fa_a", fa_a, 1);
    #3 rst = 1'b1;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_sum", sum, 0);
    checkOutput("midreset_cout", cout, 0);
    checkOutput("midreset_fa", {fa_a, fa_b, fa_c}, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_idle", busy, 0);
    runAndCheck(post_vec, 0, "post_reset");

    // Slow cell: settle of 1 is too short, settle of 3 is enough.
    s1_cyc = 0;
    s3_cyc = 0;
    s1_res = '0;
    s3_res = '0;
    s3_co  = 1'b0;
    @(negedge clk);
    a          = 8'h55;
    b          = 8'h00;
    cin        = 1'b0;
    start_slow = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_slow = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (s1_done === 1'b1 && s1_cyc == 0) begin
        s1_cyc = cyc;
        s1_res = s1_sum;
      end
      if (s3_done === 1'b1 && s3_cyc == 0) begin
        s3_cyc = cyc;
        s3_res = s3_sum;
        s3_co  = s3_cout;
      end
    end
    checkOutput("settle1_done_cycle", s1_cyc, W * 2 + 1);
    checkOutput("settle3_done_cycle", s3_cyc, W * 4 + 1);
    checkOutput("settle3_sum", s3_res, 8'h55);
    checkOutput("settle3_cout", s3_co, 0);
    tests++;
    if (s1_res === 8'h55) begin
      fails++;
      $display("[TB] FAIL settle1_stale_detect: got %0h, required a value other than 55", s1_res);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
